mem_addr_mux: RTL and testbench
===============================

# mem_addr_mux

Registered, parametrised memory-address source selector with a request/ready handshake and an exception-vector path. Sits between the multicycle control unit and the memory port. It captures one of NSRC address sources, or a fixed vector address VEC_BASE+cause, and holds it stable on the memory address bus until memory accepts it. It can also walk a short burst of consecutive addresses.

## Interface
- WIDTH, 32, address width in bits
- NSRC, 8, number of address sources (1..2**SEL_W)
- SEL_W, 3, width of `sel`
- VEC_BASE, 253, address of exception vector 0
- NVEC, 3, number of exception vectors (causes 0..NVEC-1)
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- src_flat  in  NSRC*WIDTH  concatenated sources; source k at bits [k*WIDTH +: WIDTH]
- sel  in  SEL_W  source index, sampled with `req`
- req  in  1  start normal access
- exc_req  in  1  start exception-vector access
- exc_cause  in  2  vector index, sampled with `exc_req`
- burst_len  in  4  extra beats after the first (see Configuration)
- mem_ready  in  1  memory accepts `addr_out` this cycle
- addr_out  out  WIDTH  registered address
- addr_valid  out  1  `addr_out` is being presented
- is_exc  out  1  current or last access is a vector access
- busy  out  1  FSM not in IDLE
- done  out  1  one-cycle pulse after the last beat is accepted
- err  out  1  one-cycle pulse: illegal `sel` or `exc_cause`, request dropped

## Operation
- FSM has two states:
  - IDLE: `addr_valid`=0, `busy`=0.
  - ACTIVE: `addr_valid`=1, `busy`=1.
- In IDLE, a start request is taken in this priority order: pending exception, then `exc_req`, then `req`.
- Exception start:
  - `addr_out` ← VEC_BASE + cause, zero-extended to WIDTH.
  - `is_exc` ← 1.
  - Burst count ← 0; vector accesses are always single-beat.
- Normal start:
  - `addr_out` ← src[sel].
  - `is_exc` ← 0.
  - Burst count ← `burst_len`.
- Illegal request (`sel`≥NSRC, or cause≥NVEC): no access starts, `err` pulses, state stays IDLE.
  - If `exc_req` is illegal and `req` is legal in the same cycle, the `req` is taken.
- In ACTIVE, on `mem_ready`:
  - Burst count > 0: `addr_out` ← `addr_out`+1 (mod 2**WIDTH), count decrements, state stays ACTIVE.
  - Burst count = 0: go to IDLE and pulse `done`.
- A legal `exc_req` arriving in ACTIVE is latched as pending, with its cause.
  - It is served in the first IDLE cycle, ahead of `req`.
  - A second `exc_req` while one is pending overwrites the pending cause.
  - The current access is never aborted.
- `req` in ACTIVE is ignored. The caller watches `busy` and retries.
- Held values:
  - `addr_out` and `is_exc` keep their last values in IDLE.
  - `addr_out` never changes in ACTIVE except on an accepted beat.

## Timing
- Reset (asynchronous, any state): FSM→IDLE, pending cleared, burst count 0.
  - `addr_out`=0, `addr_valid`=0, `is_exc`=0, `busy`=0, `done`=0, `err`=0.
- Start latency: request sampled at edge N; `addr_out`/`addr_valid` are valid from edge N onward (registered).
- Single beat: if `mem_ready` is high in the first ACTIVE cycle, IDLE and `done`=1 follow one edge later.
  - Minimum of 2 cycles from request edge to the next accepted request.
- `done` is asserted exactly in the first IDLE cycle. A new `req` in that cycle is accepted.
- `err` is asserted in the cycle after the illegal sample.
- `mem_ready` while `addr_valid`=0 is ignored.
- Reset released mid-operation: no `done` is produced for the interrupted access.

## Configuration
- Macro MEM_ADDR_MUX_BURST_EN.
- Defined: burst behaviour as above. A normal access has 1+`burst_len` beats, 1..16.
- Undefined: `burst_len` is ignored and the burst counter is not built. Every access is a single beat, and `addr_out` never increments.

## Test plan
- Normal access: sel=3, src3=0x0000_1000, `mem_ready` held low 2 cycles then high → `addr_out`=0x1000 stable for 3 ACTIVE cycles, `done` 1 pulse, `is_exc`=0.
- Exception: `exc_req`, cause=2 → `addr_out`=255, `is_exc`=1. Cause=3 → `err` pulse, stays IDLE, `addr_out` unchanged.
- Pending exception: `exc_req` cause=1 during a normal access, plus `req` in the `done` cycle → next access is addr 254 with `is_exc`=1; `req` ignored.
- Burst (macro defined): src0=0xFFFF_FFFE, `burst_len`=2, `mem_ready` always high → addresses 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000, then `done`. With macro undefined: one beat, `done`.
- Priority: `req` and `exc_req` (cause 0) in the same IDLE cycle → `addr_out`=253, `req` dropped, no `err`.
- Reset mid-operation: `reset_n` low during ACTIVE with pending exception → all outputs 0 immediately, no pending service and no `done` after release.

Source files
------------

// File: rtl/mem_addr_mux.sv
// mem_addr_mux: registered memory-address source selector.
// Captures one of NSRC sources (or VEC_BASE+cause for exception vectors) on a
// request and holds it on addr_out until memory accepts it. Legal exception
// requests seen while busy are held as pending and served first once idle.
// Optional burst walking of consecutive addresses: define MEM_ADDR_MUX_BURST_EN.
module mem_addr_mux #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NSRC     = 8,
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned VEC_BASE = 253,
  parameter int unsigned NVEC     = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NSRC*WIDTH-1:0]   src_flat,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    req,
  input  logic                    exc_req,
  input  logic [1:0]              exc_cause,
  input  logic [3:0]              burst_len,
  input  logic                    mem_ready,
  output logic [WIDTH-1:0]        addr_out,
  output logic                    addr_valid,
  output logic                    is_exc,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic             is_exc_q, is_exc_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             pend_q, pend_d;
  logic [1:0]       pend_cause_q, pend_cause_d;
`ifdef MEM_ADDR_MUX_BURST_EN
  logic [3:0]       cnt_q, cnt_d;
`else
  logic             unused_burst_len;
  assign unused_burst_len = ^burst_len;
`endif

  logic             sel_ok, cause_ok;
  logic [WIDTH-1:0] src_sel, vec_new, vec_pend;

  // Source selection and legality of the sampled request fields
  always_comb begin
    sel_ok   = (32'(sel) < NSRC);
    cause_ok = (32'(exc_cause) < NVEC);
    src_sel  = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (32'(sel) == k) src_sel = src_flat[k*WIDTH +: WIDTH];
    end
    vec_new  = WIDTH'(VEC_BASE) + WIDTH'(exc_cause);
    vec_pend = WIDTH'(VEC_BASE) + WIDTH'(pend_cause_q);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      is_exc_q     <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      pend_q       <= 1'b0;
      pend_cause_q <= '0;
`ifdef MEM_ADDR_MUX_BURST_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      is_exc_q     <= is_exc_d;
      done_q       <= done_d;
      err_q        <= err_d;
      pend_q       <= pend_d;
      pend_cause_q <= pend_cause_d;
`ifdef MEM_ADDR_MUX_BURST_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  // Next-state: start arbitration in IDLE, beat acceptance and pending latch in ACTIVE
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    is_exc_d     = is_exc_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    pend_d       = pend_q;
    pend_cause_d = pend_cause_q;
`ifdef MEM_ADDR_MUX_BURST_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          state_d  = ACTIVE;
          addr_d   = vec_pend;
          is_exc_d = 1'b1;
          pend_d   = 1'b0;
`ifdef MEM_ADDR_MUX_BURST_EN
          cnt_d    = '0;
`endif
          // A fresh exception in this cycle would otherwise be lost: re-arm pending
          if (exc_req) begin
            if (cause_ok) begin
              pend_d       = 1'b1;
              pend_cause_d = exc_cause;
            end else begin
              err_d = 1'b1;
            end
          end
        end else if (exc_req && cause_ok) begin
          state_d  = ACTIVE;
          addr_d   = vec_new;
          is_exc_d = 1'b1;
`ifdef MEM_ADDR_MUX_BURST_EN
          cnt_d    = '0;
`endif
        end else if (req && sel_ok) begin
          state_d  = ACTIVE;
          addr_d   = src_sel;
          is_exc_d = 1'b0;
`ifdef MEM_ADDR_MUX_BURST_EN
          cnt_d    = burst_len;
`endif
          err_d    = exc_req;
        end else begin
          err_d = exc_req | req;
        end
      end
      ACTIVE: begin
        if (exc_req) begin
          if (cause_ok) begin
            pend_d       = 1'b1;
            pend_cause_d = exc_cause;
          end else begin
            err_d = 1'b1;
          end
        end
        if (mem_ready) begin
`ifdef MEM_ADDR_MUX_BURST_EN
          if (cnt_q != '0) begin
            addr_d = addr_q + WIDTH'(1);
            cnt_d  = cnt_q - 4'd1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
`else
          state_d = IDLE;
          done_d  = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    addr_out   = addr_q;
    addr_valid = (state_q == ACTIVE);
    busy       = (state_q == ACTIVE);
    is_exc     = is_exc_q;
    done       = done_q;
    err        = err_q;
  end

endmodule

// File: tb/tb_mem_addr_mux.sv
// tb_mem_addr_mux: scoreboard bench for mem_addr_mux (default parameters).
// Expected beats ({is_exc, addr}) are queued when a request is driven and
// popped when the DUT presents a beat that memory accepts.
module tb_mem_addr_mux;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned NSRC  = 8;
  localparam int unsigned SEL_W = 3;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NSRC*WIDTH-1:0] src_flat;
  logic [SEL_W-1:0]      sel;
  logic                  req, exc_req, mem_ready;
  logic [1:0]            exc_cause;
  logic [3:0]            burst_len;
  logic [WIDTH-1:0]      addr_out;
  logic                  addr_valid, is_exc, busy, done, err;

  int checks   = 0;
  int failures = 0;
  logic [WIDTH:0] exp_q[$];
  logic [WIDTH:0] exp_e;

  mem_addr_mux #(.WIDTH(32), .NSRC(8), .SEL_W(3), .VEC_BASE(253), .NVEC(3)) dut (
    .clk(clk), .reset_n(reset_n), .src_flat(src_flat), .sel(sel), .req(req),
    .exc_req(exc_req), .exc_cause(exc_cause), .burst_len(burst_len),
    .mem_ready(mem_ready), .addr_out(addr_out), .addr_valid(addr_valid),
    .is_exc(is_exc), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset_n = 1'b0; req = 1'b0; exc_req = 1'b0; exc_cause = '0; sel = '0;
    burst_len = '0; mem_ready = 1'b0; src_flat = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (addr_out !== '0) begin failures++; $display("FAIL reset_addr got=%h exp=0", addr_out); end
    checks++;
    if ({addr_valid, is_exc, busy, done, err} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000", {addr_valid, is_exc, busy, done, err});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_normal();
    src_flat[3*WIDTH +: WIDTH] = 32'h0000_1000;
    @(negedge clk);
    sel = 3'd3; req = 1'b1; mem_ready = 1'b0;
    exp_q.push_back({1'b0, 32'h0000_1000});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req = 1'b0;
      checks++;
      if (addr_valid !== 1'b1 || addr_out !== 32'h0000_1000 || done !== 1'b0) begin
        failures++; $display("FAIL normal_hold cyc=%0d got v=%b a=%h d=%b exp v=1 a=00001000 d=0", i, addr_valid, addr_out, done);
      end
      if (i == 2) begin
        mem_ready = 1'b1;
        exp_e = exp_q.pop_front();
        checks++;
        if ({is_exc, addr_out} !== exp_e) begin failures++; $display("FAIL normal_beat got=%h exp=%h", {is_exc, addr_out}, exp_e); end
      end
    end
    @(negedge clk);
    mem_ready = 1'b0;
    checks++;
    if ({done, busy, is_exc} !== 3'b100) begin failures++; $display("FAIL normal_done got=%b exp=100", {done, busy, is_exc}); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL normal_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_exception();
    exc_req = 1'b1; exc_cause = 2'd2; mem_ready = 1'b1;
    exp_q.push_back({1'b1, 32'd255});
    for (int n = 0; n < 20 && exp_q.size() > 0; n++) begin
      @(negedge clk);
      exc_req = 1'b0;
      if (addr_valid) begin
        exp_e = exp_q.pop_front();
        checks++;
        if ({is_exc, addr_out} !== exp_e) begin failures++; $display("FAIL exc_beat got=%h exp=%h", {is_exc, addr_out}, exp_e); end
      end
    end
    if (exp_q.size() != 0) begin checks++; failures++; $display("FAIL exc_timeout got=%0d exp=0 pending", exp_q.size()); exp_q.delete(); end
    @(negedge clk);
    checks++;
    if ({done, is_exc} !== 2'b11) begin failures++; $display("FAIL exc_done got=%b exp=11", {done, is_exc}); end
    exc_req = 1'b1; exc_cause = 2'd3;
    @(negedge clk);
    exc_req = 1'b0;
    checks++;
    if ({err, busy} !== 2'b10 || addr_out !== 32'd255) begin
      failures++; $display("FAIL exc_illegal got err=%b busy=%b a=%h exp err=1 busy=0 a=000000ff", err, busy, addr_out);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL exc_err_pulse got=%b exp=0", err); end
  endtask

  task automatic test_pending();
    sel = 3'd3; req = 1'b1; mem_ready = 1'b0;
    exp_q.push_back({1'b0, 32'h0000_1000});
    exp_q.push_back({1'b1, 32'd254});
    @(negedge clk);
    req = 1'b0; exc_req = 1'b1; exc_cause = 2'd1;
    @(negedge clk);
    exc_req = 1'b0; mem_ready = 1'b1;
    exp_e = exp_q.pop_front();
    checks++;
    if ({is_exc, addr_out} !== exp_e || busy !== 1'b1) begin
      failures++; $display("FAIL pend_first got=%h busy=%b exp=%h busy=1", {is_exc, addr_out}, busy, exp_e);
    end
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b10) begin failures++; $display("FAIL pend_done got=%b exp=10", {done, busy}); end
    req = 1'b1; sel = 3'd3;
    @(negedge clk);
    req = 1'b0;
    exp_e = exp_q.pop_front();
    checks++;
    if ({is_exc, addr_out} !== exp_e || busy !== 1'b1) begin
      failures++; $display("FAIL pend_served got=%h busy=%b exp=%h busy=1", {is_exc, addr_out}, busy, exp_e);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL pend_served_done got=%b exp=1", done); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL pend_req_dropped got busy=%b exp=0", busy); end
  endtask

  task automatic test_burst();
    src_flat[0 +: WIDTH] = 32'hFFFF_FFFE;
    @(negedge clk);
    sel = 3'd0; burst_len = 4'd2; req = 1'b1; mem_ready = 1'b1;
    exp_q.push_back({1'b0, 32'hFFFF_FFFE});
`ifdef MEM_ADDR_MUX_BURST_EN
    exp_q.push_back({1'b0, 32'hFFFF_FFFF});
    exp_q.push_back({1'b0, 32'h0000_0000});
`endif
    for (int n = 0; n < 20 && exp_q.size() > 0; n++) begin
      @(negedge clk);
      req = 1'b0;
      if (addr_valid) begin
        exp_e = exp_q.pop_front();
        checks++;
        if ({is_exc, addr_out} !== exp_e || done !== 1'b0) begin
          failures++; $display("FAIL burst_beat got=%h done=%b exp=%h done=0", {is_exc, addr_out}, done, exp_e);
        end
      end
    end
    if (exp_q.size() != 0) begin checks++; failures++; $display("FAIL burst_timeout got=%0d exp=0 pending", exp_q.size()); exp_q.delete(); end
    @(negedge clk);
    burst_len = '0;
    checks++;
    if ({done, busy} !== 2'b10) begin failures++; $display("FAIL burst_done got=%b exp=10", {done, busy}); end
  endtask

  task automatic test_priority();
    @(negedge clk);
    sel = 3'd0; req = 1'b1; exc_req = 1'b1; exc_cause = 2'd0; mem_ready = 1'b1;
    exp_q.push_back({1'b1, 32'd253});
    @(negedge clk);
    req = 1'b0; exc_req = 1'b0;
    exp_e = exp_q.pop_front();
    checks++;
    if ({is_exc, addr_out} !== exp_e || err !== 1'b0) begin
      failures++; $display("FAIL prio_beat got=%h err=%b exp=%h err=0", {is_exc, addr_out}, err, exp_e);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL prio_done got=%b exp=1", done); end
    @(negedge clk);
    checks++;
    if ({busy, err} !== 2'b00) begin failures++; $display("FAIL prio_req_dropped got=%b exp=00", {busy, err}); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    sel = 3'd3; req = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    req = 1'b0; exc_req = 1'b1; exc_cause = 2'd2;
    @(negedge clk);
    exc_req = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_active got busy=%b exp=1", busy); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (addr_out !== '0 || {addr_valid, is_exc, busy, done, err} !== 5'b0) begin
      failures++; $display("FAIL rstmid_async got a=%h f=%b exp a=0 f=00000", addr_out, {addr_valid, is_exc, busy, done, err});
    end
    @(negedge clk);
    reset_n = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({addr_valid, busy, done} !== 3'b000) begin
        failures++; $display("FAIL rstmid_quiet cyc=%0d got=%b exp=000", i, {addr_valid, busy, done});
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_exception();
    test_pending();
    test_burst();
    test_priority();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
